// File: rtl/comb_mixer.sv
// Reverb comb-bank mixer: sums the comb outputs one per clock, applies wet/dry gains,
// saturates to one word and emits the mixed sample with a one-cycle valid pulse.
module comb_mixer #(
    parameter int WIDTH       = 24,
    parameter int N_COMB      = 4,
    // Mirrors FIXED_POINT of the shared reverb constants header.
    parameter int FIXED_POINT = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          sample_en,
    input  logic [WIDTH+FIXED_POINT-1:0]  dry_in,
    input  logic [N_COMB*(WIDTH+FIXED_POINT)-1:0] comb_in,
    input  logic [WIDTH+FIXED_POINT-1:0]  wet_gain,
    input  logic [WIDTH+FIXED_POINT-1:0]  dry_gain,
    output logic [WIDTH+FIXED_POINT-1:0]  out,
    output logic                          out_valid,
    output logic                          busy,
    output logic                          overrun
);
    localparam int WORD   = WIDTH + FIXED_POINT;
    localparam int ACC_W  = WORD + $clog2(N_COMB) + 1;
    localparam int PROD_W = 2 * WORD + $clog2(N_COMB) + 2;
    localparam int IDX_W  = (N_COMB > 1) ? $clog2(N_COMB) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        SCALE = 2'd2,
        OUT   = 2'd3
    } state_t;

    state_t                   state;
    logic signed [ACC_W-1:0]  acc;
    logic [IDX_W-1:0]         idx;
    logic signed [WORD-1:0]   comb_reg [N_COMB];
    logic signed [WORD-1:0]   dry_reg;
    logic signed [WORD-1:0]   wet_g;
    logic signed [WORD-1:0]   dry_g;
    logic signed [PROD_W-1:0] sum_reg;

    logic signed [PROD_W-1:0] acc_ext, wg_ext, dry_ext, dg_ext;
    logic signed [PROD_W-1:0] wet_p, dry_p, sum_next;
    logic [WORD-1:0]          sat_val;
    logic [PROD_W-WORD:0]     sum_hi;

    assign busy = (state != IDLE);

    // Operands are widened before multiplying so the products and their sum are exact.
    always_comb begin
        acc_ext  = {{(PROD_W-ACC_W){acc[ACC_W-1]}}, acc};
        wg_ext   = {{(PROD_W-WORD){wet_g[WORD-1]}}, wet_g};
        dry_ext  = {{(PROD_W-WORD){dry_reg[WORD-1]}}, dry_reg};
        dg_ext   = {{(PROD_W-WORD){dry_g[WORD-1]}}, dry_g};
        wet_p    = (acc_ext * wg_ext) >>> FIXED_POINT;
        dry_p    = (dry_ext * dg_ext) >>> FIXED_POINT;
        sum_next = wet_p + dry_p;
    end

    // In range exactly when every bit above the output sign bit matches it.
    always_comb begin
        sum_hi = sum_reg[PROD_W-1:WORD-1];
        if ((&sum_hi) || !(|sum_hi)) begin
            sat_val = sum_reg[WORD-1:0];
        end else if (sum_reg[PROD_W-1]) begin
            sat_val = {1'b1, {(WORD-1){1'b0}}};
        end else begin
            sat_val = {1'b0, {(WORD-1){1'b1}}};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            acc       <= '0;
            idx       <= '0;
            out       <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
            dry_reg   <= '0;
            wet_g     <= '0;
            dry_g     <= '0;
            sum_reg   <= '0;
            for (int i = 0; i < N_COMB; i++) begin
                comb_reg[i] <= '0;
            end
        end else begin
            out_valid <= 1'b0;
            overrun   <= sample_en && (state != IDLE);
            case (state)
                IDLE: begin
                    if (sample_en) begin
                        for (int i = 0; i < N_COMB; i++) begin
                            comb_reg[i] <= comb_in[i*WORD +: WORD];
                        end
                        dry_reg <= dry_in;
                        wet_g   <= wet_gain;
                        dry_g   <= dry_gain;
                        acc     <= '0;
                        idx     <= '0;
                        state   <= ACCUM;
                    end
                end
                ACCUM: begin
                    acc <= acc + {{(ACC_W-WORD){comb_reg[idx][WORD-1]}}, comb_reg[idx]};
                    idx <= idx + IDX_W'(1);
                    if (idx == IDX_W'(N_COMB - 1)) begin
                        state <= SCALE;
                    end
                end
                SCALE: begin
                    sum_reg <= sum_next;
                    state   <= OUT;
                end
                OUT: begin
                    out       <= sat_val;
                    out_valid <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
